// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with two read ports, one writeback port and a pending-write scoreboard
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_req_i,
    input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
    input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
    output logic                  rd_stall_o,
    output logic                  rd_valid_o,
    output logic [DATA_WIDTH-1:0] rs1_data_o,
    output logic [DATA_WIDTH-1:0] rs2_data_o,
    input  logic                  issue_en_i,
    input  logic [ADDR_WIDTH-1:0] issue_addr_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [NUM_REGS-1:0]   pending_mask_o
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic                  wr_ok, hazard1, hazard2, accept;

    assign wr_ok = wr_en_i && (wr_addr_i != '0);

    // A writeback landing this cycle clears the hazard because the read path bypasses it.
    assign hazard1 = pending_q[rs1_addr_i] && !(wr_en_i && (wr_addr_i == rs1_addr_i));
    assign hazard2 = pending_q[rs2_addr_i] && !(wr_en_i && (wr_addr_i == rs2_addr_i));

    assign rd_stall_o = rd_req_i && (hazard1 || hazard2);
    assign accept     = rd_req_i && !rd_stall_o;

    always_comb begin
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        if (accept) begin
            if (rs1_addr_i == '0)                              rs1_d = '0;
            else if (wr_en_i && (wr_addr_i == rs1_addr_i))     rs1_d = wr_data_i;
            else                                               rs1_d = regs_q[rs1_addr_i];
            if (rs2_addr_i == '0)                              rs2_d = '0;
            else if (wr_en_i && (wr_addr_i == rs2_addr_i))     rs2_d = wr_data_i;
            else                                               rs2_d = regs_q[rs2_addr_i];
        end
    end

    // Issue is applied after writeback so a same-address pair leaves the bit set.
    always_comb begin
        pending_d = pending_q;
        if (wr_ok)
            pending_d[wr_addr_i] = 1'b0;
        if (issue_en_i && (issue_addr_i != '0))
            pending_d[issue_addr_i] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs_q[i] <= '0;
            pending_q  <= '0;
            rd_valid_q <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
        end else begin
            if (wr_ok)
                regs_q[wr_addr_i] <= wr_data_i;
            pending_q  <= pending_d;
            rd_valid_q <= accept;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
        end
    end

    assign rd_valid_o     = rd_valid_q;
    assign rs1_data_o     = rs1_q;
    assign rs2_data_o     = rs2_q;
    assign pending_mask_o = pending_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - directed bench for regfile_scoreboard with a reference model checked every cycle
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rd_stall, rd_valid;
    logic [31:0] rs1_data, rs2_data;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] pending_mask;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .reset(reset),
        .rd_req_i(rd_req), .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
        .rd_stall_o(rd_stall), .rd_valid_o(rd_valid),
        .rs1_data_o(rs1_data), .rs2_data_o(rs2_data),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .pending_mask_o(pending_mask)
    );

    // Reference model: architectural registers, set of outstanding destinations, last read result.
    logic [31:0] m_regs [32];
    logic [31:0] m_pend;
    logic        m_valid;
    logic [31:0] m_d1, m_d2;
    bit          m_started = 0;

    function automatic logic m_blocked(input logic [4:0] a);
        return (a != 0) && m_pend[a] && !(wr_en && wr_addr == a);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wr_en && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
            m_pend = 32'h0; m_valid = 0; m_d1 = 0; m_d2 = 0;
            m_started = 1;
        end else if (m_started) begin
            m_valid = rd_req && !(m_blocked(rs1_addr) || m_blocked(rs2_addr));
            if (m_valid) begin
                m_d1 = m_read(rs1_addr);
                m_d2 = m_read(rs2_addr);
            end
            if (wr_en && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (issue_en && issue_addr != 0) m_pend[issue_addr] = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_started) begin
            chk("model_stall", {31'b0, rd_stall},
                {31'b0, rd_req && (m_blocked(rs1_addr) || m_blocked(rs2_addr))});
            chk("model_valid", {31'b0, rd_valid}, {31'b0, m_valid});
            chk("model_rs1", rs1_data, m_d1);
            chk("model_rs2", rs2_data, m_d2);
            chk("model_pending", pending_mask, m_pend);
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        rd_req = 0; rs1_addr = 0; rs2_addr = 0;
        issue_en = 0; issue_addr = 0;
        wr_en = 0; wr_addr = 0; wr_data = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        rd_req = 1; rs1_addr = a1; rs2_addr = a2;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset = 1;
        wr(3, 32'hDEAD_BEEF);
        issue_en = 1; issue_addr = 4;
        rd(3, 0);
        cyc(); cyc();
        chk("reset_valid", {31'b0, rd_valid}, 32'h0);
        chk("reset_pending", pending_mask, 32'h0);
        reset = 0; idle();
        #1;
        chk("reset_stall", {31'b0, rd_stall}, 32'h0);

        rd(3, 0); cyc(); idle();
        chk("post_reset_valid", {31'b0, rd_valid}, 32'h1);
        chk("post_reset_rs1", rs1_data, 32'h0);
        chk("post_reset_rs2", rs2_data, 32'h0);
        cyc();
        chk("valid_pulse", {31'b0, rd_valid}, 32'h0);

        wr(5, 32'h1234_5678); cyc();
        wr(0, 32'hFFFF_FFFF); cyc(); idle();
        rd(5, 0); cyc(); idle();
        chk("r5_valid", {31'b0, rd_valid}, 32'h1);
        chk("r5_data", rs1_data, 32'h1234_5678);
        chk("r0_data", rs2_data, 32'h0);

        wr(7, 32'hCAFE_0001); rd(7, 5); #1;
        chk("bypass_stall", {31'b0, rd_stall}, 32'h0);
        cyc(); idle();
        chk("bypass_rs1", rs1_data, 32'hCAFE_0001);
        chk("bypass_rs2", rs2_data, 32'h1234_5678);

        issue_en = 1; issue_addr = 9; cyc(); idle();
        chk("issue9_pending", pending_mask, 32'h0000_0200);
        rd(0, 9);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall9", {31'b0, rd_stall}, 32'h1);
            cyc();
            chk("stall9_novalid", {31'b0, rd_valid}, 32'h0);
        end
        wr(9, 32'hA5A5_A5A5); #1;
        chk("wb9_stall", {31'b0, rd_stall}, 32'h0);
        cyc(); idle();
        chk("wb9_valid", {31'b0, rd_valid}, 32'h1);
        chk("wb9_rs2", rs2_data, 32'hA5A5_A5A5);
        chk("wb9_pending", pending_mask, 32'h0);

        wr(12, 32'h0BAD_F00D); issue_en = 1; issue_addr = 12; cyc(); idle();
        chk("r12_pending", pending_mask, 32'h0000_1000);
        rd(12, 5); #1;
        chk("r12_stall", {31'b0, rd_stall}, 32'h1);
        cyc();
        chk("r12_novalid", {31'b0, rd_valid}, 32'h0);
        idle();

        // Issue and read of the same register in one cycle: the read sees the old scoreboard.
        issue_en = 1; issue_addr = 6; rd(6, 7); #1;
        chk("issue_same_cycle_stall", {31'b0, rd_stall}, 32'h0);
        cyc(); idle();
        chk("issue_same_cycle_rs2", rs2_data, 32'hCAFE_0001);

        for (int i = 1; i <= 8; i++) begin
            if (i != 6) begin
                wr(5'(i + 16), 32'h1000_0000 + 32'(i) * 32'h111); cyc();
            end
        end
        idle();
        for (int i = 1; i <= 8; i++) begin
            if (i != 6) begin
                rd(5'(i + 16), 5'(i + 15)); cyc();
                chk("b2b_valid", {31'b0, rd_valid}, 32'h1);
            end
        end
        idle();
        chk("b2b_last_rs1", rs1_data, 32'h1000_0888);
        chk("b2b_last_rs2", rs2_data, 32'h1000_0777);

        issue_en = 1; issue_addr = 4; cyc(); idle();
        rd(4, 0); #1;
        chk("r4_stall", {31'b0, rd_stall}, 32'h1);
        reset = 1; cyc(); reset = 0; #1;
        chk("mid_reset_pending", pending_mask, 32'h0);
        chk("mid_reset_stall", {31'b0, rd_stall}, 32'h0);
        cyc(); idle();
        chk("mid_reset_valid", {31'b0, rd_valid}, 32'h1);
        chk("mid_reset_rs1", rs1_data, 32'h0);
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
